// File: rtl/fir_decim_out_if.sv
// Sample stream into the FIR output stage and the valid/ready stream out of it.
// The master modport is the side that drives samples and consumes results.
interface fir_decim_out_if #(
  parameter int unsigned OUT_W = 8
);
  logic signed [15:0]      din;
  logic                    din_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    sat;
  logic                    overflow;

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid, sat, overflow
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid, sat, overflow
  );
endinterface

// File: rtl/fir_decim_out.sv
// FIR output stage: DECIM:1 decimation, rounded arithmetic shift, saturation to OUT_W bits,
// then a small FIFO behind a valid/ready handshake.
module fir_decim_out #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned SHIFT      = 7,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  fir_decim_out_if.slave  bus
);
  localparam int unsigned PhW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  localparam logic signed [16:0] Half = 17'(1 << (SHIFT - 1));
  localparam logic signed [16:0] MaxV = 17'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [16:0] MinV = -MaxV - 17'sd1;

  logic [PhW-1:0]          phase_q;
  logic                    stage_valid_q;
  logic signed [OUT_W-1:0] stage_data_q;
  logic                    sat_q;
  logic                    overflow_q;
  logic signed [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;

  logic                    keep;
  logic signed [16:0]      sum, r;
  logic signed [OUT_W-1:0] sat_val;
  logic                    clip;
  logic                    push, pop, full, wr_en;

  assign keep = bus.din_valid && (phase_q == '0);

  always_comb begin
    sum     = $signed({bus.din[15], bus.din}) + Half;
    r       = sum >>> SHIFT;
    clip    = 1'b0;
    sat_val = r[OUT_W-1:0];
    if (r > MaxV) begin
      sat_val = MaxV[OUT_W-1:0];
      clip    = 1'b1;
    end else if (r < MinV) begin
      sat_val = MinV[OUT_W-1:0];
      clip    = 1'b1;
    end
  end

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push  = stage_valid_q;
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && bus.dout_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      sat_q         <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      if (bus.din_valid) begin
        phase_q <= (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + PhW'(1);
      end
      stage_valid_q <= keep;
      sat_q         <= keep && clip;
      if (keep) begin
        stage_data_q <= sat_val;
      end
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!wr_en && pop) begin
        count_q <= count_q - CW'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= stage_data_q;
    end
  end

  assign bus.dout_valid = (count_q != '0);
  assign bus.dout       = bus.dout_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.sat        = sat_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: decimation, rounding, saturation, backpressure,
// full-FIFO push/pop and mid-stream reset, with hand-computed expectations.
module tb_fir_decim_out;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fir_decim_out_if #(.OUT_W(8)) bus ();

  fir_decim_out #(
    .DECIM(4),
    .SHIFT(7),
    .OUT_W(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v, input logic valid);
    bus.din       = 16'(v);
    bus.din_valid = valid;
    step();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One kept sample followed by three discarded ones, leaving phase back at 0.
  task automatic send_kept(input int v);
    feed(v, 1'b1);
    feed(0, 1'b1);
    feed(0, 1'b1);
    feed(0, 1'b1);
  endtask

  int rnd_in  [4] = '{64, 63, -64, -65};
  int rnd_exp [4] = '{1, 0, 0, -1};
  int sat_in  [2] = '{32767, -32768};
  int sat_exp [2] = '{127, -128};

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;

    do_reset();
    check("rst_dout_valid", 32'(bus.dout_valid), 0);
    check("rst_dout", $signed(bus.dout), 0);
    check("rst_sat", 32'(bus.sat), 0);
    check("rst_overflow", 32'(bus.overflow), 0);

    // Decimation: 640 -> (640+64)>>7 = 5, visible in cycles 1, 5, 9, 13.
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      feed(640, 1'b1);
      check($sformatf("dec_valid_%0d", i), 32'(bus.dout_valid), (i % 4 == 1) ? 1 : 0);
      check($sformatf("dec_dout_%0d", i), $signed(bus.dout), (i % 4 == 1) ? 5 : 0);
      check($sformatf("dec_sat_%0d", i), 32'(bus.sat), 0);
    end
    feed(0, 1'b0);
    check("dec_idle_valid", 32'(bus.dout_valid), 0);

    // Rounding half-up.
    do_reset();
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(rnd_in[i], 1'b1);
      check($sformatf("rnd_sat_%0d", i), 32'(bus.sat), 0);
      feed(0, 1'b1);
      check($sformatf("rnd_valid_%0d", i), 32'(bus.dout_valid), 1);
      check($sformatf("rnd_dout_%0d", i), $signed(bus.dout), rnd_exp[i]);
      feed(0, 1'b1);
      feed(0, 1'b1);
    end

    // Saturation with a one-cycle sat pulse per clipped sample.
    for (int i = 0; i < 2; i++) begin
      feed(sat_in[i], 1'b1);
      check($sformatf("sat_pulse_%0d", i), 32'(bus.sat), 1);
      feed(0, 1'b1);
      check($sformatf("sat_clear_%0d", i), 32'(bus.sat), 0);
      check($sformatf("sat_dout_%0d", i), $signed(bus.dout), sat_exp[i]);
      feed(0, 1'b1);
      feed(0, 1'b1);
    end

    // Backpressure: six kept samples into a four-entry FIFO.
    do_reset();
    bus.dout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send_kept(k * 128);
    check("bp_count", 32'(dut.count_q), 4);
    check("bp_overflow", 32'(bus.overflow), 1);
    check("bp_head", $signed(bus.dout), 1);
    bus.dout_ready = 1'b1;
    bus.din_valid  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_valid_%0d", k), 32'(bus.dout_valid), 1);
      check($sformatf("bp_dout_%0d", k), $signed(bus.dout), k);
      step();
    end
    check("bp_empty_valid", 32'(bus.dout_valid), 0);
    check("bp_empty_dout", $signed(bus.dout), 0);
    check("bp_overflow_sticky", 32'(bus.overflow), 1);

    // Full FIFO with a pop in the same cycle as a push.
    do_reset();
    bus.dout_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_kept(k * 128);
    check("full_count", 32'(dut.count_q), 4);
    feed(5 * 128, 1'b1);
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    check("full_head", $signed(bus.dout), 1);
    step();
    check("full_count_kept", 32'(dut.count_q), 4);
    check("full_no_overflow", 32'(bus.overflow), 0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("full_dout_%0d", k), $signed(bus.dout), k);
      step();
    end
    check("full_empty_valid", 32'(bus.dout_valid), 0);

    // Reset with three entries buffered and phase mid-count.
    do_reset();
    bus.dout_ready = 1'b0;
    send_kept(128);
    send_kept(256);
    feed(384, 1'b1);
    feed(0, 1'b1);
    check("mid_count", 32'(dut.count_q), 3);
    check("mid_phase", 32'(dut.phase_q), 2);
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    step();
    reset = 1'b0;
    check("rst2_valid", 32'(bus.dout_valid), 0);
    check("rst2_dout", $signed(bus.dout), 0);
    check("rst2_overflow", 32'(bus.overflow), 0);
    check("rst2_phase", 32'(dut.phase_q), 0);
    feed(0, 1'b0);
    feed(0, 1'b0);
    check("rst2_idle_valid", 32'(bus.dout_valid), 0);
    feed(3 * 128, 1'b1);
    feed(0, 1'b0);
    check("rst2_first_valid", 32'(bus.dout_valid), 1);
    check("rst2_first_dout", $signed(bus.dout), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
